// File: rtl/multi_accumulator_pkg.sv
// Shared types and defaults for the multi-channel accumulator.
package multi_accumulator_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/edge_fall_det.sv
// Falling-edge pulse for an active-low strobe.
// Armed only after the strobe is seen high, so a low level at reset release is ignored.
module edge_fall_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;
  logic arm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
      if (sig_i) begin
        arm_q <= 1'b1;
      end
    end
  end

  assign fall_o = arm_q & sig_q & ~sig_i;

endmodule

// File: rtl/multi_accumulator.sv
// Bank of independent add/sub accumulators with sticky overflow flags.
// Define MULTI_ACCUMULATOR_SAT_EN to clamp results instead of wrapping.
module multi_accumulator
  import multi_accumulator_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             add_ni,
  input  logic             clr_ni,
  input  logic [SW-1:0]    sel_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] number_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             done_o
);

  logic [WIDTH-1:0]    acc_q [CHANNELS];
  logic [WIDTH-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                ovf_oq, ovf_od;
  logic                done_q, done_d;

  logic             fall;
  logic             sel_ok;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] res;
  logic             flow;

  edge_fall_det u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (add_ni),
    .fall_o (fall)
  );

  assign sel_ok = (32'(sel_i) < CHANNELS);
  assign cur    = sel_ok ? acc_q[sel_i] : '0;
  assign sum_w  = {1'b0, cur} + {1'b0, number_i};
  assign dif_w  = {1'b0, cur} - {1'b0, number_i};

  always_comb begin
    res  = sum_w[WIDTH-1:0];
    flow = sum_w[WIDTH];
    unique case (op_e'(op_i))
      OP_ADD: begin
        res  = sum_w[WIDTH-1:0];
        flow = sum_w[WIDTH];
`ifdef MULTI_ACCUMULATOR_SAT_EN
        if (flow) res = '1;
`endif
      end
      OP_SUB: begin
        res  = dif_w[WIDTH-1:0];
        flow = dif_w[WIDTH];
`ifdef MULTI_ACCUMULATOR_SAT_EN
        if (flow) res = '0;
`endif
      end
      default: ;
    endcase
  end

  // Clear shares sel_i with the operation, so it always targets the same channel and wins.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (sel_ok) begin
      if (!clr_ni) begin
        acc_d[sel_i] = '0;
        ovf_d[sel_i] = 1'b0;
      end else if (fall) begin
        acc_d[sel_i] = res;
        ovf_d[sel_i] = ovf_q[sel_i] | flow;
        done_d       = 1'b1;
      end
    end
  end

  assign result_d = cur;
  assign ovf_od   = sel_ok ? ovf_q[sel_i] : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q    <= '0;
      result_q <= '0;
      ovf_oq   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      ovf_oq   <= ovf_od;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign ovf_o    = ovf_oq;
  assign done_o   = done_q;

endmodule

// File: tb/tb_multi_accumulator.sv
// Randomized and directed bench for multi_accumulator (WIDTH=8, CHANNELS=4).
module tb_multi_accumulator;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk;
  logic         rst_ni;
  logic         add_ni;
  logic         clr_ni;
  logic [1:0]   sel_i;
  logic         op_i;
  logic [W-1:0] number_i;
  logic [W-1:0] result_o;
  logic         ovf_o;
  logic         done_o;

  int passed = 0;
  int total  = 0;

  int unsigned m_acc [C];
  bit          m_ovf [C];
`ifdef MULTI_ACCUMULATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  multi_accumulator #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .add_ni   (add_ni),
    .clr_ni   (clr_ni),
    .sel_i    (sel_i),
    .op_i     (op_i),
    .number_i (number_i),
    .result_o (result_o),
    .ovf_o    (ovf_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < C; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void m_op(input int ch, input bit sub, input int num);
    int s;
    if (!sub) begin
      s = m_acc[ch] + num;
      if (s > 255) begin
        m_ovf[ch] = 1'b1;
        s = SAT ? 255 : s - 256;
      end
    end else begin
      s = m_acc[ch] - num;
      if (s < 0) begin
        m_ovf[ch] = 1'b1;
        s = SAT ? 0 : s + 256;
      end
    end
    m_acc[ch] = s;
  endfunction

  task automatic read(input int ch, input string tag);
    sel_i = 2'(ch);
    step();
    check({tag, "_res"}, int'(result_o), m_acc[ch]);
    check({tag, "_ovf"}, int'(ovf_o), int'(m_ovf[ch]));
  endtask

  task automatic do_op(input int ch, input bit sub, input int num,
                       input bit clr, input string tag);
    add_ni = 1'b1;
    sel_i  = 2'(ch);
    step();
    op_i     = sub;
    number_i = W'(num);
    add_ni   = 1'b0;
    clr_ni   = ~clr;
    step();
    check({tag, "_done"}, int'(done_o), clr ? 0 : 1);
    if (clr) begin
      m_acc[ch] = 0;
      m_ovf[ch] = 1'b0;
    end else begin
      m_op(ch, sub, num);
    end
    clr_ni   = 1'b1;
    add_ni   = 1'b1;
    op_i     = 1'($urandom);
    number_i = W'($urandom);
    step();
    check({tag, "_done0"}, int'(done_o), 0);
    check({tag, "_res"}, int'(result_o), m_acc[ch]);
    check({tag, "_ovf"}, int'(ovf_o), int'(m_ovf[ch]));
  endtask

  initial begin
    int pulses;
    rst_ni   = 1'b0;
    add_ni   = 1'b1;
    clr_ni   = 1'b1;
    sel_i    = '0;
    op_i     = 1'b0;
    number_i = '0;
    m_reset();
    step();
    check("rst_res", int'(result_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    check("rst_done", int'(done_o), 0);
    rst_ni = 1'b1;
    step();

    for (int k = 0; k < 3; k++) do_op(2, 1'b0, 5, 1'b0, "basic");
    for (int ch = 0; ch < C; ch++) read(ch, "basic_rd");

    add_ni = 1'b1;
    sel_i  = 2'd0;
    step();
    add_ni   = 1'b0;
    number_i = 8'd7;
    step();
    check("held_done", int'(done_o), 1);
    m_op(0, 1'b0, 7);
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      number_i = W'($urandom);
      step();
      pulses += int'(done_o);
    end
    check("held_extra", pulses, 0);
    add_ni = 1'b1;
    step();
    read(0, "held_rd");

    do_op(1, 1'b0, 250, 1'b0, "ovf_pre");
    do_op(1, 1'b0, 10, 1'b0, "ovf");
    do_op(3, 1'b0, 3, 1'b0, "udf_pre");
    do_op(3, 1'b1, 5, 1'b0, "udf");

    do_op(0, 1'b0, 13, 1'b0, "clr_pre");
    do_op(0, 1'b0, 9, 1'b1, "clr");
    read(0, "clr_rd");

    read(2, "rst_pre");
    add_ni = 1'b1;
    step();
    add_ni = 1'b0;
    number_i = 8'd1;
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_res", int'(result_o), 0);
    check("arst_ovf", int'(ovf_o), 0);
    check("arst_done", int'(done_o), 0);
    m_reset();
    #2;
    rst_ni = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      pulses += int'(done_o);
    end
    check("arst_noop", pulses, 0);
    for (int ch = 0; ch < C; ch++) read(ch, "arst_rd");

    for (int k = 0; k < 60; k++) begin
      do_op($urandom_range(0, C - 1), 1'($urandom_range(0, 1)),
            $urandom_range(0, 255), $urandom_range(0, 7) == 0, "rand");
    end
    for (int ch = 0; ch < C; ch++) read(ch, "final_rd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
